// File: rtl/fact_pkg.sv
// Shared constants for the factorial datapath: widths and the controller's
// three-state encoding.
package fact_pkg;

    localparam int unsigned OPERAND_W = 64;
    localparam int unsigned RESULT_W  = 128;
    localparam int unsigned BITCNT_W  = 6;

    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_MULT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/fact_mul_serial.sv
// 128x64 LSB-first shift-add multiplier: one multiplier bit per step cycle,
// product available on acc_next_c_o in the cycle step_done_c_o is high.
module fact_mul_serial
    import fact_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_i,
    input  logic                 arm_i,
    input  logic                 step_i,
    input  logic [RESULT_W-1:0]  mcand_i,
    input  logic [OPERAND_W-1:0] mplier_i,
    output logic [RESULT_W-1:0]  acc_next_c_o,
    output logic                 step_done_c_o
);

    logic [RESULT_W-1:0]  acc_q,    acc_d;
    logic [RESULT_W-1:0]  mcand_q,  mcand_d;
    logic [OPERAND_W-1:0] mplier_q, mplier_d;
    logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;

    assign acc_next_c_o  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign step_done_c_o = step_i && (bitcnt_q == BITCNT_W'(OPERAND_W - 1));

    // Clear beats arm, arm beats step so a re-arm can replace the final step.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        bitcnt_d = bitcnt_q;
        if (clear_i) begin
            acc_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
            bitcnt_d = '0;
        end else if (arm_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            bitcnt_d = '0;
        end else if (step_i) begin
            acc_d    = acc_next_c_o;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            bitcnt_d = bitcnt_q + BITCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            bitcnt_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            bitcnt_q <= bitcnt_d;
        end
    end

endmodule

// File: rtl/fact_mult_core.sv
// Factorial datapath: INIT/MULT/DONE sequencer, factor down-counter and result
// register around a serial multiplier. N! is kept modulo 2^128.
module fact_mult_core
    import fact_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [OPERAND_W-1:0] operand,
    output logic [RESULT_W-1:0]  result,
    output logic                 op_done,
    output logic [1:0]           state
);

    logic [1:0]           state_q,  state_d;
    logic [RESULT_W-1:0]  result_q, result_d;
    logic [OPERAND_W-1:0] factor_q, factor_d;
    logic                 op_done_q, op_done_d;

    logic                 clr_c, arm_c, step_c;
    logic [RESULT_W-1:0]  arm_mcand_c;
    logic [OPERAND_W-1:0] arm_mplier_c;
    logic [RESULT_W-1:0]  acc_next_c;
    logic                 step_done_c;
    logic [OPERAND_W-1:0] factor_dec_c;
    logic                 last_step_c;

    assign factor_dec_c = factor_q - OPERAND_W'(1);
    assign last_step_c  = factor_dec_c < OPERAND_W'(2);

    fact_mul_serial u_mul (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_i       (clr_c),
        .arm_i         (arm_c),
        .step_i        (step_c),
        .mcand_i       (arm_mcand_c),
        .mplier_i      (arm_mplier_c),
        .acc_next_c_o  (acc_next_c),
        .step_done_c_o (step_done_c)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_INIT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (op_clear) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: if (op_start) state_d = (operand <= OPERAND_W'(2)) ? ST_DONE : ST_MULT;
                ST_MULT: if (step_done_c && last_step_c) state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_INIT;
            endcase
        end
    end

    // op_done trails entry into DONE by one edge; clear drops it immediately.
    always_comb begin
        result_d     = result_q;
        factor_d     = factor_q;
        op_done_d    = (state_q == ST_DONE);
        clr_c        = 1'b0;
        arm_c        = 1'b0;
        step_c       = 1'b0;
        arm_mcand_c  = '0;
        arm_mplier_c = '0;
        if (op_clear || state_q == 2'b11) begin
            result_d  = '0;
            factor_d  = '0;
            op_done_d = 1'b0;
            clr_c     = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (op_start) begin
                        result_d = (operand < OPERAND_W'(2)) ? RESULT_W'(1) : RESULT_W'(operand);
                        if (operand > OPERAND_W'(2)) begin
                            factor_d     = operand - OPERAND_W'(1);
                            arm_c        = 1'b1;
                            arm_mcand_c  = RESULT_W'(operand);
                            arm_mplier_c = operand - OPERAND_W'(1);
                        end
                    end
                end
                ST_MULT: begin
                    step_c = 1'b1;
                    if (step_done_c) begin
                        result_d = acc_next_c;
                        factor_d = factor_dec_c;
                        if (!last_step_c) begin
                            arm_c        = 1'b1;
                            arm_mcand_c  = acc_next_c;
                            arm_mplier_c = factor_dec_c;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_q  <= '0;
            factor_q  <= '0;
            op_done_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            factor_q  <= factor_d;
            op_done_q <= op_done_d;
        end
    end

    assign result  = result_q;
    assign op_done = op_done_q;
    assign state   = state_q;

endmodule

// File: tb/tb_fact_mult_core.sv
// Directed bench for fact_mult_core: a cycle-level behavioural model checked
// every cycle, plus hand-computed factorial and latency expectations.
module tb_fact_mult_core;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         op_start;
    logic         op_clear;
    logic [63:0]  operand;
    logic [127:0] result;
    logic         op_done;
    logic [1:0]   state;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    fact_mult_core dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_start (op_start),
        .op_clear (op_clear),
        .operand  (operand),
        .result   (result),
        .op_done  (op_done),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Behavioural model: product built with '*', one factor every 64 edges.
    logic [1:0]   m_state;
    logic         m_done;
    logic [127:0] m_result;
    logic [127:0] m_fac;
    int           m_t;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_state = 2'd0; m_done = 1'b0; m_result = '0; m_fac = '0; m_t = 0;
        end else begin
            m_done = (m_state == 2'd2) && !op_clear;
            if (op_clear) begin
                m_state = 2'd0; m_result = '0; m_fac = '0; m_t = 0;
            end else if (m_state == 2'd0) begin
                if (op_start) begin
                    if (operand <= 64'd2) begin
                        m_result = (operand < 64'd2) ? 128'd1 : {64'd0, operand};
                        m_state  = 2'd2;
                    end else begin
                        m_result = {64'd0, operand};
                        m_fac    = {64'd0, operand} - 128'd1;
                        m_t      = 0;
                        m_state  = 2'd1;
                    end
                end
            end else if (m_state == 2'd1) begin
                m_t = m_t + 1;
                if (m_t == 64) begin
                    m_t      = 0;
                    m_result = m_result * m_fac;
                    m_fac    = m_fac - 128'd1;
                    if (m_fac < 128'd2) m_state = 2'd2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (state !== m_state || op_done !== m_done || result !== m_result) begin
                n_bad++;
                $display("FAIL model t=%0t: got state=%0d done=%0b result=%0h, expected state=%0d done=%0b result=%0h",
                         $time, state, op_done, result, m_state, m_done, m_result);
            end
        end
    end

    function automatic logic [127:0] fact(input int n);
        logic [127:0] f;
        f = 128'd1;
        for (int i = 2; i <= n; i++) f = f * 128'(i);
        return f;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] n);
        op_start = 1'b1;
        operand  = n;
        tick();
        op_start = 1'b0;
    endtask

    task automatic clear();
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        chk("clear_state", {126'd0, state}, 128'd0);
        chk("clear_result", result, 128'd0);
        chk("clear_done", {127'd0, op_done}, 128'd0);
    endtask

    // Count edges after the start edge until op_done; bounded by limit.
    task automatic wait_done(input int limit, output int c);
        c = 0;
        while (!op_done && c < limit) begin
            tick();
            c++;
        end
    endtask

    int lat;

    initial begin
        reset_n  = 1'b0;
        op_start = 1'b0;
        op_clear = 1'b0;
        operand  = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_state", {126'd0, state}, 128'd0);
        chk("reset_result", result, 128'd0);
        chk("reset_done", {127'd0, op_done}, 128'd0);
        reset_n = 1'b1;
        tick();

        chk("model_fact34", fact(34), 128'd295232799039604140847618609643520000000);

        start(64'd5);
        chk("n5_state_mult", {126'd0, state}, 128'd1);
        wait_done(400, lat);
        chk("n5_latency", 128'(lat), 128'd193);
        chk("n5_result", result, 128'd120);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("n5_hold", result, 128'd120);
        end
        clear();

        for (int n = 0; n <= 2; n++) begin
            start(64'(n));
            wait_done(10, lat);
            chk("small_latency", 128'(lat), 128'd1);
            chk("small_result", result, (n == 2) ? 128'd2 : 128'd1);
            clear();
        end

        start(64'd20);
        wait_done(1300, lat);
        chk("n20_latency", 128'(lat), 128'd1153);
        chk("n20_result", result, 128'h21C3677C82B40000);
        clear();

        start(64'd34);
        wait_done(2200, lat);
        chk("n34_latency", 128'(lat), 128'd2049);
        chk("n34_result", result, 128'd295232799039604140847618609643520000000);
        clear();

        start(64'd35);
        wait_done(2300, lat);
        chk("n35_wrap", result, 128'(fact(35)));
        clear();

        start(64'd10);
        repeat (100) tick();
        clear();
        start(64'd3);
        wait_done(100, lat);
        chk("n3_latency", 128'(lat), 128'd65);
        chk("n3_result", result, 128'd6);
        clear();

        start(64'd4);
        repeat (10) tick();
        op_start = 1'b1;
        operand  = 64'd9;
        tick();
        op_start = 1'b0;
        wait_done(300, lat);
        chk("n4_ignore_restart", result, 128'd24);
        clear();
        op_start = 1'b1;
        op_clear = 1'b1;
        operand  = 64'd7;
        tick();
        op_start = 1'b0;
        op_clear = 1'b0;
        chk("start_clear_state", {126'd0, state}, 128'd0);
        tick();
        chk("start_clear_stay", {126'd0, state}, 128'd0);

        start(64'd6);
        repeat (50) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midreset_state", {126'd0, state}, 128'd0);
        chk("midreset_result", result, 128'd0);
        chk("midreset_done", {127'd0, op_done}, 128'd0);
        start(64'd6);
        wait_done(400, lat);
        chk("n6_latency", 128'(lat), 128'd257);
        chk("n6_result", result, 128'd720);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
